// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream framing constants for the boot loader
package imem_loader_pkg;
  typedef enum logic [2:0] {CNT, DATA, WR, CSUM, RUN, ERR} ldr_state_t;
  localparam int CNT_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: places incoming bytes little-endian into a 32-bit word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);
  logic [1:0] cnt;
  assign full = load & (cnt == 2'(BYTES_PER_WORD - 1));
  // byte slot pointer advances per accepted byte and wraps after the last one
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      word[{cnt, 3'b000} +: 8] <= din;
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: holds the core in reset while loading and checksumming a program into imem
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ImemWE,
  output logic [31:0] ImemAdr,
  output logic [31:0] ImemWD,
  output logic        CoreReset,
  output logic        Done,
  output logic        Error
);
  localparam int IDX_W = $clog2(DEPTH) + 1;
  ldr_state_t       state, nxt;
  logic             hb;
  logic [CNT_W-1:0] count, new_cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       csum;
  logic [31:0]      adr_q, wd_q, word, live_adr;
  logic             xfer, full, last_hdr, last_word;
  assign in_ready  = reset & (state == CNT || state == DATA || state == CSUM);
  assign xfer      = in_valid & in_ready;
  assign ImemWE    = reset & (state == WR);
  assign Done      = reset & (state == RUN);
  assign Error     = reset & (state == ERR);
  assign CoreReset = ~Done;
  assign live_adr  = {{(30-IDX_W){1'b0}}, idx, 2'b00};
  assign ImemAdr   = ImemWE ? live_adr : adr_q;
  assign ImemWD    = ImemWE ? word : wd_q;
  assign last_hdr  = hb == 1'(CNT_BYTES - 1);
  assign new_cnt   = CNT_W'({in_data, count[7:0]});
  assign last_word = CNT_W'(idx) + CNT_W'(1) == count;
  word_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .load  (xfer && state == DATA),
    .clear (state == CNT),
    .din   (in_data),
    .word  (word),
    .full  (full)
  );
  // next-state: header check, word collection, single write cycle, checksum verdict
  always_comb begin
    nxt = state;
    case (state)
      CNT:     if (xfer && last_hdr) nxt = (new_cnt == '0 || new_cnt > CNT_W'(DEPTH)) ? ERR : DATA;
      DATA:    if (full) nxt = WR;
      WR:      nxt = last_word ? CSUM : DATA;
      CSUM:    if (xfer) nxt = (in_data == csum) ? RUN : ERR;
      default: nxt = state;
    endcase
  end
  // state, header count, word index, running checksum and held write-port values
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CNT;
      hb    <= 1'b0;
      count <= '0;
      idx   <= '0;
      csum  <= '0;
      adr_q <= '0;
      wd_q  <= '0;
    end else begin
      state <= nxt;
      if (xfer && state != CSUM) csum <= csum ^ in_data;
      if (xfer && state == CNT) begin
        hb <= ~hb;
        if (!last_hdr) count[7:0] <= in_data;
        else count <= new_cnt;
      end
      if (state == WR) begin
        idx   <= idx + IDX_W'(1);
        adr_q <= live_adr;
        wd_q  <= word;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of header, write, checksum, error and abort behaviour
module tb_imem_loader;
  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, ImemWE, CoreReset, Done, Error;
  logic [31:0] ImemAdr, ImemWD;
  int          vectors = 0, miscompares = 0, xfers = 0, rdy_wr = 0;
  logic [31:0] wa[$], wd[$];

  imem_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ImemWE(ImemWE), .ImemAdr(ImemAdr), .ImemWD(ImemWD), .CoreReset(CoreReset),
    .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset && in_valid && in_ready) xfers++;

  always @(negedge clk)
    if (ImemWE) begin
      wa.push_back(ImemAdr);
      wd.push_back(ImemWD);
      if (in_ready) rdy_wr++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      miscompares++;
      $error("FAIL ready_timeout: observed in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(ImemWE), 0);
    chk("rst_core", 32'(CoreReset), 1);
    chk("rst_done_err", {30'b0, Done, Error}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    wa.delete();
    wd.delete();
    xfers = 0;
    rdy_wr = 0;
  endtask

  initial begin
    // single word, full rate
    do_reset();
    @(negedge clk);
    chk("post_rst_adr", ImemAdr, 0);
    chk("post_rst_wd", ImemWD, 0);
    @(posedge clk); #1;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'hA0, 0); send(8'hE3, 0);
    @(negedge clk);
    chk("t1_we_latency", 32'(ImemWE), 1);
    chk("t1_core_before", 32'(CoreReset), 1);
    send(8'h51, 0);
    @(negedge clk);
    chk("t1_done", 32'(Done), 1);
    chk("t1_core", 32'(CoreReset), 0);
    chk("t1_nwr", wa.size(), 1);
    chk("t1_adr", wa[0], 32'h0);
    chk("t1_wd", wd[0], 32'hE3A00013);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_run_ready", 32'(in_ready), 0);
    chk("t1_run_done", {30'b0, Done, Error}, 2);
    // three words with random stalls
    do_reset();
    send(8'h03, 1); send(8'h00, 2);
    send(8'h44, $urandom_range(0, 2)); send(8'h33, $urandom_range(0, 2));
    send(8'h22, $urandom_range(0, 2)); send(8'h11, $urandom_range(0, 2));
    send(8'hEF, $urandom_range(0, 2)); send(8'hBE, $urandom_range(0, 2));
    send(8'hAD, $urandom_range(0, 2)); send(8'hDE, $urandom_range(0, 2));
    send(8'h01, $urandom_range(0, 2)); send(8'h00, $urandom_range(0, 2));
    send(8'h00, $urandom_range(0, 2)); send(8'h00, $urandom_range(0, 2));
    send(8'h64, 1);
    @(negedge clk);
    chk("t2_done", 32'(Done), 1);
    chk("t2_nwr", wa.size(), 3);
    chk("t2_adr0", wa[0], 32'h0);
    chk("t2_wd0", wd[0], 32'h11223344);
    chk("t2_adr1", wa[1], 32'h4);
    chk("t2_wd1", wd[1], 32'hDEADBEEF);
    chk("t2_adr2", wa[2], 32'h8);
    chk("t2_wd2", wd[2], 32'h00000001);
    chk("t2_ready_in_wr", rdy_wr, 0);
    chk("t2_xfers", xfers, 15);
    // zero count header
    do_reset();
    send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("t3_error", 32'(Error), 1);
    chk("t3_core", 32'(CoreReset), 1);
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("t3_ready", 32'(in_ready), 0);
    chk("t3_xfers", xfers, 2);
    chk("t3_nwr", wa.size(), 0);
    chk("t3_done", 32'(Done), 0);
    // count one past depth
    do_reset();
    send(8'h41, 0); send(8'h00, 0);
    @(negedge clk);
    chk("t4_error", 32'(Error), 1);
    chk("t4_nwr", wa.size(), 0);
    // count equal to depth
    do_reset();
    send(8'h40, 0); send(8'h00, 0);
    for (int i = 0; i < 64; i++) begin
      send(8'(i), 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    end
    send(8'h40, 0);
    @(negedge clk);
    chk("t4_done", 32'(Done), 1);
    chk("t4_nwr", wa.size(), 64);
    chk("t4_last_adr", wa[63], 32'hFC);
    chk("t4_last_wd", wd[63], 32'd63);
    chk("t4_mid_adr", wa[17], 32'h44);
    // checksum off by one
    do_reset();
    send(8'h01, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'hA0, 0); send(8'hE3, 0);
    send(8'h52, 0);
    @(negedge clk);
    chk("t5_nwr", wa.size(), 1);
    chk("t5_error", 32'(Error), 1);
    chk("t5_done", 32'(Done), 0);
    chk("t5_core", 32'(CoreReset), 1);
    // reset mid-word then fresh load
    do_reset();
    send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
    do_reset();
    send(8'h01, 0); send(8'h00, 0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    send(8'h09, 0);
    @(negedge clk);
    chk("t6_nwr", wa.size(), 1);
    chk("t6_adr", wa[0], 32'h0);
    chk("t6_wd", wd[0], 32'h12345678);
    chk("t6_done", 32'(Done), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory, which the core otherwise only reads.
- Holds the single-cycle ARM core in reset while it accepts a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit words, writes them sequentially from address 0 through a new imem write port, verifies a trailing XOR checksum, then releases the core.
- Sits in top between the external byte source (UART receiver or bench) and imem.

Parameters:
- DEPTH, 64, instruction memory depth in words; the maximum legal word count.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  byte source has in_data available
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts in_data this cycle
- ImemWE  output  1  imem write strobe, one cycle per word
- ImemAdr  output  32  imem byte address, word aligned
- ImemWD  output  32  imem write data
- CoreReset  output  1  active-high reset to the arm core
- Done  output  1  program loaded and checksum good; sticky
- Error  output  1  bad count or checksum mismatch; sticky

Behaviour:
- Reset: sampled on posedge clk when reset=0.
  - State <= CNT; CoreReset=1; in_ready=0, ImemWE=0, Done=0, Error=0 during the reset cycle.
  - ImemAdr=0, ImemWD=0; byte counter, word index and checksum all cleared.
  - Reset asserted mid-load aborts the load immediately. Partially written imem contents are don't-care. The core stays in reset.
- Handshake: a byte transfers on a posedge where in_valid & in_ready. in_ready is high only in CNT, DATA and CSUM, and is combinational from state only (never from in_valid). in_valid low simply stalls; there is no timeout.
- Checksum register: csum <= csum ^ in_data on every transfer in CNT and DATA. The CSUM byte itself is not folded in.
- States and transitions:
  - CNT: accept 2 bytes, low byte first, into count[CNT_W-1:0]. After the 2nd byte: if count==0 or count>DEPTH -> ERR, else -> DATA.
  - DATA: accept bytes into the word assembler, little-endian (1st byte -> [7:0], 4th byte -> [31:24]). After the 4th byte -> WR.
  - WR (exactly 1 cycle): ImemWE=1, ImemAdr={index,2'b00}, ImemWD=assembled word. Then index++; if index==count -> CSUM, else -> DATA.
  - CSUM: accept 1 byte. Equal to csum -> RUN; otherwise -> ERR.
  - RUN: CoreReset=0, Done=1. Terminal until reset.
  - ERR: Error=1, CoreReset=1. Terminal until reset.
- Latency: the 4th byte of a word accepted at edge t gives ImemWE high for the cycle following t. Minimum 5 cycles per word. Load time is 3 + 5*count cycles at full rate.
- Outside WR: ImemWE=0. ImemAdr/ImemWD hold their last values (don't-care to imem).
- Done and Error are never both 1. CoreReset = ~Done at all times.
- Index width is clog2(DEPTH)+1 so that index==DEPTH is representable. There is no address wrap: count<=DEPTH guarantees the highest address is 4*(DEPTH-1).
- in_valid held high in RUN/ERR: no transfer, no effect.

Decomposition:
- Package imem_loader_pkg:
  - typedef enum logic [2:0] {CNT, DATA, WR, CSUM, RUN, ERR} ldr_state_t
  - constants CNT_BYTES=2, BYTES_PER_WORD=4
- Sub-module word_assembler:
  - 4-byte little-endian shift/placement register with a 2-bit byte counter
  - inputs: clk, reset, load strobe, byte, clear
  - outputs: word, full (4th byte accepted)
- FSM, index counter and checksum live in imem_loader.

Test Plan:
- Count=1, word bytes 13 00 A0 E3, csum=01^00^13^00^A0^E3=0x51, in_valid always high -> one ImemWE pulse with ImemAdr=0, ImemWD=0xE3A00013; CoreReset falls and Done=1 on the cycle after the csum byte.
- Count=3 with in_valid toggled randomly -> ImemWE pulses at addresses 0x0, 0x4, 0x8 with correct words; in_ready never high in WR; transfers occur only on valid&ready.
- Count=0 header (00 00) -> Error=1 the cycle after the 2nd byte; no ImemWE; CoreReset stays 1; further bytes not accepted.
- Count=65 (41 00) with DEPTH=64 -> Error=1, no writes. Count=64 -> 64 writes, last ImemAdr=0xFC, then Done.
- Valid load but csum byte off by 1 -> all words written, then Error=1, Done=0, CoreReset=1.
- reset driven low for 1 cycle after 2 of 4 data bytes, then a fresh 1-word stream -> first write at ImemAdr=0 with the new word; the old partial bytes do not appear in ImemWD.
